// File: rtl/video_pkg.sv
// Shared 480p video definitions.
//   CORDW     : screen coordinate width in bits
//   H_RES     : active pixels per line
//   V_RES     : active lines per frame
//   rgb444_t  : 4:4:4 colour as packed r/g/b nibbles
package video_pkg;

  localparam int unsigned CORDW = 10;
  localparam int unsigned H_RES = 640;
  localparam int unsigned V_RES = 480;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

endpackage

// File: rtl/bounce_axis.sv
// One axis of the bouncing square: position register plus direction flag.
// Advances by SPEED on each step, clamping to [0, LIM] and reversing at the
// limits.
//   clk_pix : pixel clock
//   rst_n   : asynchronous active-low reset (pos = START clamped to LIM)
//   step    : advance this cycle
//   pos     : current position (top-left corner on this axis)
//   reflect : this cycle's step would hit an edge (valid whenever step is high)
module bounce_axis #(
  parameter int unsigned CORDW = video_pkg::CORDW,
  parameter int unsigned LIM   = 608,
  parameter int unsigned SPEED = 2,
  parameter int unsigned START = 0
) (
  input  logic             clk_pix,
  input  logic             rst_n,
  input  logic             step,
  output logic [CORDW-1:0] pos,
  output logic             reflect
);

  localparam logic [CORDW-1:0] START_C = CORDW'((START > LIM) ? LIM : START);
  localparam logic [CORDW:0]   LIM_W   = (CORDW+1)'(LIM);
  localparam logic [CORDW:0]   SPD_W   = (CORDW+1)'(SPEED);

  logic           dir;     // 0 = positive, 1 = negative
  logic [CORDW:0] fwd;     // one bit wider so pos + SPEED cannot wrap
  logic           hit_hi;
  logic           hit_lo;

  always_comb begin
    fwd     = {1'b0, pos} + SPD_W;
    hit_hi  = (fwd >= LIM_W);
    hit_lo  = ({1'b0, pos} <= SPD_W);
    reflect = dir ? hit_lo : hit_hi;
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      pos <= START_C;
      dir <= 1'b0;
    end else if (step) begin
      if (!dir) begin
        if (hit_hi) begin
          pos <= LIM_W[CORDW-1:0];
          dir <= 1'b1;
        end else begin
          pos <= fwd[CORDW-1:0];
        end
      end else begin
        if (hit_lo) begin
          pos <= '0;
          dir <= 1'b0;
        end else begin
          pos <= pos - SPD_W[CORDW-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/square_bounce.sv
// Moving-square renderer for the 480p VGA pipeline (clk_pix domain).
// Draws a SIZE x SIZE square in FG_RGB over BG_RGB and moves it once per
// frame, on the first pixel of vertical blank, reflecting off screen edges.
//   clk_pix, rst_n          : pixel clock, asynchronous active-low reset
//   sx, sy                  : beam position from display timings
//   hsync, vsync, de        : timing signals from display timings
//   run                     : 1 = animate, 0 = hold position
//   vga_hsync, vga_vsync    : syncs delayed 1 cycle
//   vga_r, vga_g, vga_b     : colour, 1 cycle latency (aligned with syncs)
//   bounce                  : 1-cycle pulse after an update that reflected
module square_bounce #(
  parameter int unsigned CORDW   = video_pkg::CORDW,
  parameter int unsigned H_RES   = video_pkg::H_RES,
  parameter int unsigned V_RES   = video_pkg::V_RES,
  parameter int unsigned SIZE    = 32,
  parameter int unsigned SPEED   = 2,
  parameter int unsigned START_X = 0,
  parameter int unsigned START_Y = 0,
  parameter logic [11:0] FG_RGB  = 12'hF80,
  parameter logic [11:0] BG_RGB  = 12'h08F
) (
  input  logic             clk_pix,
  input  logic             rst_n,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             de,
  input  logic             run,
  output logic             vga_hsync,
  output logic             vga_vsync,
  output logic [3:0]       vga_r,
  output logic [3:0]       vga_g,
  output logic [3:0]       vga_b,
  output logic             bounce
);

  import video_pkg::*;

  localparam int unsigned    LIM_X  = H_RES - SIZE;
  localparam int unsigned    LIM_Y  = V_RES - SIZE;
  localparam logic [CORDW:0] SIZE_W = (CORDW+1)'(SIZE);
  localparam rgb444_t        FG     = FG_RGB;
  localparam rgb444_t        BG     = BG_RGB;

  logic             frame;
  logic             step;
  logic [CORDW-1:0] x;
  logic [CORDW-1:0] y;
  logic             refl_x;
  logic             refl_y;
  logic [CORDW:0]   x_end;
  logic [CORDW:0]   y_end;
  logic             q_draw;
  rgb444_t          pix;

  always_comb begin
    frame = (sy == CORDW'(V_RES)) && (sx == '0);
    step  = frame && run;
  end

  bounce_axis #(
    .CORDW (CORDW),
    .LIM   (LIM_X),
    .SPEED (SPEED),
    .START (START_X)
  ) u_axis_x (
    .clk_pix (clk_pix),
    .rst_n   (rst_n),
    .step    (step),
    .pos     (x),
    .reflect (refl_x)
  );

  bounce_axis #(
    .CORDW (CORDW),
    .LIM   (LIM_Y),
    .SPEED (SPEED),
    .START (START_Y)
  ) u_axis_y (
    .clk_pix (clk_pix),
    .rst_n   (rst_n),
    .step    (step),
    .pos     (y),
    .reflect (refl_y)
  );

  always_comb begin
    x_end  = {1'b0, x} + SIZE_W;
    y_end  = {1'b0, y} + SIZE_W;
    q_draw = (sx >= x) && ({1'b0, sx} < x_end) &&
             (sy >= y) && ({1'b0, sy} < y_end);
    pix    = de ? (q_draw ? FG : BG) : '0;
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      vga_hsync <= 1'b0;
      vga_vsync <= 1'b0;
      vga_r     <= '0;
      vga_g     <= '0;
      vga_b     <= '0;
      bounce    <= 1'b0;
    end else begin
      vga_hsync <= hsync;
      vga_vsync <= vsync;
      vga_r     <= pix.r;
      vga_g     <= pix.g;
      vga_b     <= pix.b;
      // a frozen strobe leaves bounce as it was; any other cycle clears it
      if (frame) begin
        if (run) bounce <= refl_x || refl_y;
      end else begin
        bounce <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_square_bounce.sv
module tb_square_bounce;

  logic       clk_pix = 1'b0;
  logic       rst_n   = 1'b0;
  logic [9:0] sx = '0, sy = '0;
  logic       hsync = 1'b0, vsync = 1'b0, de = 1'b0, run = 1'b0;

  logic       hs0, vs0, bn0, hs1, vs1, bn1;
  logic [3:0] r0, g0, b0, r1, g1, b1;

  always #5 clk_pix = ~clk_pix;

  // default configuration
  square_bounce u_dut0 (
    .clk_pix (clk_pix), .rst_n (rst_n), .sx (sx), .sy (sy),
    .hsync (hsync), .vsync (vsync), .de (de), .run (run),
    .vga_hsync (hs0), .vga_vsync (vs0),
    .vga_r (r0), .vga_g (g0), .vga_b (b0), .bounce (bn0)
  );

  // odd step, start X beyond limit (clamps), distinct colours
  square_bounce #(
    .SIZE (37), .SPEED (3), .START_X (700), .START_Y (5),
    .FG_RGB (12'h0F0), .BG_RGB (12'h123)
  ) u_dut1 (
    .clk_pix (clk_pix), .rst_n (rst_n), .sx (sx), .sy (sy),
    .hsync (hsync), .vsync (vsync), .de (de), .run (run),
    .vga_hsync (hs1), .vga_vsync (vs1),
    .vga_r (r1), .vga_g (g1), .vga_b (b1), .bounce (bn1)
  );

  // ---------------- reference model ----------------
  // axis index k = dut*2 + (0 for X, 1 for Y)
  int mp  [4];
  bit md  [4];
  int lim [4] = '{640-32, 480-32, 640-37, 480-37};
  int spd [2] = '{2, 3};
  int sz  [2] = '{32, 37};
  int fg  [2] = '{'hF80, 'h0F0};
  int bg  [2] = '{'h08F, 'h123};
  bit mb  [2];
  int n_bounce;

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function void model_reset();
    mp[0] = imin(0, lim[0]);   mp[1] = imin(0, lim[1]);
    mp[2] = imin(700, lim[2]); mp[3] = imin(5, lim[3]);
    for (int k = 0; k < 4; k++) md[k] = 1'b0;
    mb[0] = 1'b0; mb[1] = 1'b0;
  endfunction

  // move one axis by the signed velocity, clamp to [0,lim], report reflection
  function bit axis_step(int k, int s);
    int t;
    t = md[k] ? mp[k] - s : mp[k] + s;
    if (t >= lim[k]) begin mp[k] = lim[k]; md[k] = 1'b1; return 1'b1; end
    if (t <= 0)      begin mp[k] = 0;      md[k] = 1'b0; return 1'b1; end
    mp[k] = t;
    return 1'b0;
  endfunction

  typedef struct packed {
    logic [14:0] e0;
    logic [14:0] e1;
  } exp_t;
  exp_t q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h (hs,vs,bounce,rgb)", name, $time, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_pix);
      #2;
      if (rst_n && q.size() > 0) begin
        e = q.pop_front();
        check("dut0_out", {hs0, vs0, bn0, r0, g0, b0}, e.e0);
        check("dut1_out", {hs1, vs1, bn1, r1, g1, b1}, e.e1);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_dut0", {hs0, vs0, bn0, r0, g0, b0}, 15'd0);
    check("rst_dut1", {hs1, vs1, bn1, r1, g1, b1}, 15'd0);
    model_reset();
    repeat (3) @(negedge clk_pix);
    check("rst_hold0", {hs0, vs0, bn0, r0, g0, b0}, 15'd0);
    check("rst_hold1", {hs1, vs1, bn1, r1, g1, b1}, 15'd0);
    rst_n = 1'b1;
  endtask

  task automatic drive_cycle(input bit freeze);
    int   rsel, tgt, sxv, syv, xd, yd;
    bit   hsv, vsv, dev, runv, frm, draw;
    logic [11:0] col [2];
    exp_t e;
    rsel = $urandom_range(0, 99);
    tgt  = $urandom_range(0, 1);
    if (rsel < 20) begin
      sxv = 0; syv = 480;
    end else if (rsel < 25) begin
      sxv = $urandom_range(1, 1023); syv = 480;
    end else if (rsel < 35) begin
      sxv = $urandom_range(0, 1023); syv = $urandom_range(0, 1023);
    end else begin
      sxv = mp[2*tgt]   + $urandom_range(0, sz[tgt] + 6) - 3;
      syv = mp[2*tgt+1] + $urandom_range(0, sz[tgt] + 6) - 3;
      if (sxv < 0) sxv = 0;
      if (syv < 0) syv = 0;
    end
    hsv  = 1'($urandom_range(0, 1));
    vsv  = 1'($urandom_range(0, 1));
    dev  = ($urandom_range(0, 3) != 0);
    runv = freeze ? 1'b0 : ($urandom_range(0, 7) != 0);
    frm  = (syv == 480) && (sxv == 0);

    for (int d = 0; d < 2; d++) begin
      xd   = mp[2*d];
      yd   = mp[2*d+1];
      draw = (sxv >= xd) && (sxv < xd + sz[d]) && (syv >= yd) && (syv < yd + sz[d]);
      col[d] = !dev ? 12'h000 : (draw ? 12'(fg[d]) : 12'(bg[d]));
      if (frm) begin
        if (runv) begin
          bit rx, ry;
          rx = axis_step(2*d,   spd[d]);
          ry = axis_step(2*d+1, spd[d]);
          mb[d] = rx | ry;
          if (mb[d]) n_bounce++;
        end
      end else begin
        mb[d] = 1'b0;
      end
    end
    e.e0 = {hsv, vsv, mb[0], col[0]};
    e.e1 = {hsv, vsv, mb[1], col[1]};
    q.push_back(e);

    sx = 10'(sxv); sy = 10'(syv);
    hsync = hsv; vsync = vsv; de = dev; run = runv;
  endtask

  initial begin
    n_bounce = 0;
    model_reset();
    @(negedge clk_pix);
    apply_reset();
    for (int i = 0; i < 24000; i++) begin
      @(negedge clk_pix);
      if (i == 9000) begin
        // mid-stream reset: queue is drained by the monitor at the last edge
        apply_reset();
      end else begin
        drive_cycle((i >= 15000) && (i < 15600));
      end
    end
    repeat (3) @(negedge clk_pix);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d entries left, expected 0", q.size());
    end
    n_checks++;
    if (n_bounce < 4) begin
      n_fail++;
      $display("FAIL bounce_coverage: %0d reflections modelled, expected at least 4", n_bounce);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
